// File: rtl/dbus_pkg.sv
// Shared definitions for the data-side bus controller: region codes, FSM states, defaults.
package dbus_pkg;

   localparam logic [3:0]  REG_RAM          = 4'h0;
   localparam logic [3:0]  REG_PERI         = 4'h1;
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {StIdle, StRamRd, StPeri, StResp} state_e;

   typedef enum logic [1:0] {RegionRam, RegionPeri, RegionNone} region_e;

   // Map the top address nibble onto a target.
   function automatic region_e decode_region(input logic [3:0] top);
      if (top == REG_RAM) begin
         return RegionRam;
      end else if (top == REG_PERI) begin
         return RegionPeri;
      end
      return RegionNone;
   endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port data SRAM: 32-bit words, per-byte write enables, one-cycle registered read.
module dmem_sram #(
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [3:0]    wr_be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [0:(1<<AW)-1];

   // Byte-lane writes and registered read share the single address port.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (rd_en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dbus_ctrl.sv
// Data bus controller: decodes core load/store requests to SRAM, peripheral bus or unmapped space.
module dbus_ctrl
   import dbus_pkg::*;
#(
   parameter int unsigned RAM_AW   = 12,
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic [31:0] d_addr,
   input  logic        d_wr_req,
   input  logic [31:0] d_wr_data,
   input  logic [3:0]  d_wr_be,
   output logic        d_wr_ready,
   input  logic        d_rd_req,
   output logic        d_rd_ready,
   output logic [31:0] d_rd_data,
   output logic        p_req,
   output logic        p_wr,
   output logic [31:0] p_addr,
   output logic [31:0] p_wdata,
   output logic [3:0]  p_be,
   input  logic [31:0] p_rdata,
   input  logic        p_ack,
   output logic        bus_err,
   output logic [31:0] err_addr,
   input  logic        err_clr
);

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] resp_q, resp_d;
   logic        resp_wr_q, resp_wr_d;
   logic        p_wr_q, p_wr_d;
   logic [31:0] p_addr_q, p_addr_d;
   logic [31:0] p_wdata_q, p_wdata_d;
   logic [3:0]  p_be_q, p_be_d;
   logic        bus_err_q, bus_err_d;
   logic [31:0] err_addr_q, err_addr_d;

   logic        err_raise;
   logic [31:0] err_src;
   logic        sram_rd;
   logic [3:0]  sram_be;
   logic        wr_ready_idle;
   logic [31:0] sram_q;
   region_e     region;

   assign region = decode_region(d_addr[31:28]);

   dmem_sram #(
      .AW (RAM_AW)
   ) u_sram (
      .clk   (clk),
      .rd_en (sram_rd),
      .wr_be (sram_be & {4{rstb}}),
      .addr  (d_addr[RAM_AW+1:2]),
      .wdata (d_wr_data),
      .rdata (sram_q)
   );

   // Next-state, request capture and error raise; reads win over writes in IDLE.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      resp_d        = resp_q;
      resp_wr_d     = resp_wr_q;
      p_wr_d        = p_wr_q;
      p_addr_d      = p_addr_q;
      p_wdata_d     = p_wdata_q;
      p_be_d        = p_be_q;
      err_raise     = 1'b0;
      err_src       = d_addr;
      sram_rd       = 1'b0;
      sram_be       = 4'h0;
      wr_ready_idle = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (d_rd_req || d_wr_req) begin
               unique case (region)
                  RegionRam: begin
                     if (d_rd_req) begin
                        sram_rd = 1'b1;
                        state_d = StRamRd;
                     end else begin
                        sram_be       = d_wr_be;
                        wr_ready_idle = 1'b1;
                     end
                  end
                  RegionPeri: begin
                     p_wr_d    = ~d_rd_req;
                     p_addr_d  = d_addr;
                     p_wdata_d = d_wr_data;
                     p_be_d    = d_wr_be;
                     resp_wr_d = ~d_rd_req;
                     cnt_d     = 8'd0;
                     state_d   = StPeri;
                  end
                  default: begin
                     resp_d    = ERR_DATA;
                     resp_wr_d = ~d_rd_req;
                     err_raise = 1'b1;
                     state_d   = StResp;
                  end
               endcase
            end
         end
         StRamRd: state_d = StIdle;
         StPeri: begin
            // An ack on the final allowed cycle still counts as a normal completion.
            if (p_ack) begin
               if (!p_wr_q) begin
                  resp_d = p_rdata;
               end
               state_d = StResp;
            end else if (cnt_q == TimeoutCnt) begin
               resp_d    = ERR_DATA;
               err_raise = 1'b1;
               err_src   = p_addr_q;
               state_d   = StResp;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Sticky error capture: first address is kept; a raise coinciding with a clear wins.
   always_comb begin
      bus_err_d  = bus_err_q;
      err_addr_d = err_addr_q;
      if (err_raise) begin
         bus_err_d = 1'b1;
         if (!bus_err_q || err_clr) begin
            err_addr_d = err_src;
         end
      end else if (err_clr) begin
         bus_err_d  = 1'b0;
         err_addr_d = 32'h0;
      end
   end

   // State and capture registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         resp_q     <= 32'h0;
         resp_wr_q  <= 1'b0;
         p_wr_q     <= 1'b0;
         p_addr_q   <= 32'h0;
         p_wdata_q  <= 32'h0;
         p_be_q     <= 4'h0;
         bus_err_q  <= 1'b0;
         err_addr_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         resp_q     <= resp_d;
         resp_wr_q  <= resp_wr_d;
         p_wr_q     <= p_wr_d;
         p_addr_q   <= p_addr_d;
         p_wdata_q  <= p_wdata_d;
         p_be_q     <= p_be_d;
         bus_err_q  <= bus_err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign p_req      = (state_q == StPeri);
   assign p_wr       = p_wr_q;
   assign p_addr     = p_addr_q;
   assign p_wdata    = p_wdata_q;
   assign p_be       = p_be_q;
   assign bus_err    = bus_err_q;
   assign err_addr   = err_addr_q;
   assign d_wr_ready = rstb & (wr_ready_idle | ((state_q == StResp) & resp_wr_q));
   assign d_rd_ready = rstb & ((state_q == StRamRd) | ((state_q == StResp) & ~resp_wr_q));
   assign d_rd_data  = (state_q == StRamRd) ? sram_q : resp_q;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Scoreboard bench for dbus_ctrl: driver pushes expected responses, monitor pops on each ready.
module tb_dbus_ctrl;

   localparam int unsigned TO   = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic [31:0] d_addr = '0;
   logic        d_wr_req = 1'b0;
   logic [31:0] d_wr_data = '0;
   logic [3:0]  d_wr_be = '0;
   logic        d_wr_ready;
   logic        d_rd_req = 1'b0;
   logic        d_rd_ready;
   logic [31:0] d_rd_data;
   logic        p_req, p_wr;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_be;
   logic [31:0] p_rdata;
   logic        p_ack;
   logic        bus_err;
   logic [31:0] err_addr;
   logic        err_clr = 1'b0;

   dbus_ctrl #(
      .RAM_AW   (12),
      .TIMEOUT  (TO),
      .ERR_DATA (ERRD)
   ) dut (
      .clk        (clk),
      .rstb       (rstb),
      .d_addr     (d_addr),
      .d_wr_req   (d_wr_req),
      .d_wr_data  (d_wr_data),
      .d_wr_be    (d_wr_be),
      .d_wr_ready (d_wr_ready),
      .d_rd_req   (d_rd_req),
      .d_rd_ready (d_rd_ready),
      .d_rd_data  (d_rd_data),
      .p_req      (p_req),
      .p_wr       (p_wr),
      .p_addr     (p_addr),
      .p_wdata    (p_wdata),
      .p_be       (p_be),
      .p_rdata    (p_rdata),
      .p_ack      (p_ack),
      .bus_err    (bus_err),
      .err_addr   (err_addr),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
      int          cyc;
      string       name;
   } exp_t;
   exp_t sb[$];

   // Reference state
   logic [31:0] mem_m [int];
   bit          err_m = 1'b0;
   logic [31:0] err_addr_m = '0;

   // Peripheral responder controls
   int          ack_k = 0;
   logic [31:0] rdata_v = '0;
   logic        rsp_ack = 1'b0;
   logic        man_ack = 1'b0;
   int          preq_cnt = 0;
   int          preq_len = 0;
   logic [31:0] exp_p_addr = '0, exp_p_wdata = '0;
   logic        exp_p_wr = 1'b0;
   logic [3:0]  exp_p_be = '0;

   assign p_ack   = rsp_ack | man_ack;
   assign p_rdata = rdata_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Monitor: every ready pulse must match the oldest expected response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstb && (d_rd_ready || d_wr_ready)) begin
            check("ready_exclusive", 32'(d_rd_ready & d_wr_ready), 32'h0);
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_ready: rd=%b wr=%b at cycle %0d, none expected",
                        d_rd_ready, d_wr_ready, cyc);
            end else begin
               e = sb.pop_front();
               check({e.name, "_dir"}, 32'(d_rd_ready), 32'(e.is_rd));
               check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
               if (e.is_rd) check({e.name, "_rdata"}, d_rd_data, e.data);
            end
         end
      end
   end

   // Peripheral: acks on the ack_k-th cycle of p_req; checks the registered request.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstb || !p_req) begin
            preq_cnt = 0;
            rsp_ack  = 1'b0;
         end else begin
            preq_cnt++;
            preq_len = preq_cnt;
            if (preq_cnt == 1) begin
               check("p_addr", p_addr, exp_p_addr);
               check("p_wr", 32'(p_wr), 32'(exp_p_wr));
               if (exp_p_wr) begin
                  check("p_wdata", p_wdata, exp_p_wdata);
                  check("p_be", 32'(p_be), 32'(exp_p_be));
               end
            end
            rsp_ack = (preq_cnt == ack_k);
         end
      end
   end

   task automatic wait_ready(input bit is_rd, input string name);
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (is_rd ? d_rd_ready : d_wr_ready) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
            err_clr = 1'b0;
         end
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_no_ready: got no ready within 40 cycles, expected one", name);
      end
   endtask

   task automatic check_err(input string name);
      check({name, "_bus_err"}, 32'(bus_err), 32'(err_m));
      check({name, "_err_addr"}, err_addr, err_addr_m);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      check_err("idle");
      d_rd_req = 1'b0;
      d_wr_req = 1'b0;
      err_clr  = 1'b0;
   endtask

   // One single-direction request; ack = p_req cycle that acks (0 or > TO+1: never).
   task automatic xact(input string name, input bit is_rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int ack,
                       input bit clr);
      exp_t e;
      int   lat, k, plen;
      bit   err;
      logic [3:0] rg;
      rg = addr[31:28];
      k  = int'(addr[13:2]);
      @(posedge clk);
      #1;
      check_err({name, "_pre"});
      if (clr) begin
         err_m      = 1'b0;
         err_addr_m = '0;
      end
      err    = 1'b0;
      plen   = 0;
      e.is_rd = is_rd;
      e.name  = name;
      e.data  = ERRD;
      if (rg == 4'h0) begin
         lat = is_rd ? 1 : 0;
         if (is_rd) e.data = mem_m[k];
      end else if (rg == 4'h1) begin
         if (ack >= 1 && ack <= int'(TO) + 1) begin
            lat    = ack + 1;
            e.data = rdata_v;
            plen   = ack;
         end else begin
            lat  = int'(TO) + 2;
            err  = 1'b1;
            plen = int'(TO) + 1;
         end
      end else begin
         lat = 1;
         err = 1'b1;
      end
      exp_p_addr  = addr;
      exp_p_wr    = !is_rd;
      exp_p_wdata = wdata;
      exp_p_be    = be;
      ack_k       = ack;
      d_addr      = addr;
      d_rd_req    = is_rd;
      d_wr_req    = !is_rd;
      d_wr_data   = wdata;
      d_wr_be     = be;
      err_clr     = clr;
      e.cyc = cyc + lat;
      sb.push_back(e);
      if (rg == 4'h0 && !is_rd) mem_m[k] = merge(mem_m[k], wdata, be);
      if (err && !err_m) begin
         err_m      = 1'b1;
         err_addr_m = addr;
      end
      wait_ready(is_rd, name);
      if (rg == 4'h1) check({name, "_preq_len"}, 32'(preq_len), 32'(plen));
   endtask

   initial begin
      exp_t e;
      logic [31:0] tmp, addr;
      logic [3:0]  rg;
      int          seen;

      // Reset, with a RAM store held high: ready must stay low throughout.
      d_wr_req = 1'b1;
      d_addr   = 32'h0000_0100;
      d_wr_be  = 4'hF;
      repeat (3) begin
         @(negedge clk);
         check("rst_wr_ready", 32'(d_wr_ready), 32'h0);
         check("rst_rd_ready", 32'(d_rd_ready), 32'h0);
      end
      check("rst_d_rd_data", d_rd_data, 32'h0);
      check("rst_p_req", 32'(p_req), 32'h0);
      check("rst_p_wr", 32'(p_wr), 32'h0);
      check("rst_p_addr", p_addr, 32'h0);
      check("rst_p_wdata", p_wdata, 32'h0);
      check("rst_p_be", 32'(p_be), 32'h0);
      check("rst_bus_err", 32'(bus_err), 32'h0);
      check("rst_err_addr", err_addr, 32'h0);
      @(posedge clk);
      #1;
      d_wr_req = 1'b0;
      rstb     = 1'b1;

      for (int w = 0; w < 16; w++) xact("init", 1'b0, 32'(w * 4), $urandom(), 4'hF, 0, 1'b0);

      xact("wr_full", 1'b0, 32'h0000_0010, 32'h1122_3344, 4'hF, 0, 1'b0);
      xact("rd_full", 1'b1, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0);
      xact("wr_byte", 1'b0, 32'h0000_0010, 32'h00AB_0000, 4'h4, 0, 1'b0);
      xact("rd_byte", 1'b1, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0);
      check("model_byte_merge", mem_m[4], 32'h11AB_3344);

      rdata_v = 32'hCAFE_0001;
      xact("peri_rd", 1'b1, 32'h1000_0004, 32'h0, 4'h0, 3, 1'b0);
      xact("peri_wr_to", 1'b0, 32'h1000_0000, 32'h5A5A_1234, 4'h3, 0, 1'b0);
      idle();
      check("to_bus_err", 32'(bus_err), 32'h1);
      check("to_err_addr", err_addr, 32'h1000_0000);
      xact("unmapped_rd", 1'b1, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0);
      idle();
      check("second_err_addr", err_addr, 32'h1000_0000);
      xact("clr", 1'b0, 32'h0000_0004, 32'h0BAD_F00D, 4'hF, 0, 1'b1);
      idle();
      check("clr_bus_err", 32'(bus_err), 32'h0);
      check("clr_err_addr", err_addr, 32'h0);

      rdata_v = 32'h1357_9BDF;
      xact("peri_ack_edge", 1'b1, 32'h1000_0010, 32'h0, 4'h0, int'(TO) + 1, 1'b0);
      xact("peri_wr_ack1", 1'b0, 32'h1FFF_FFFC, 32'hFEED_0042, 4'h9, 1, 1'b0);
      idle();
      check("ack_edge_no_err", 32'(bus_err), 32'h0);
      xact("unmapped_wr", 1'b0, 32'h8000_0000, 32'h0, 4'hF, 0, 1'b0);
      xact("clr_raise", 1'b1, 32'h2000_0040, 32'h0, 4'h0, 0, 1'b1);
      idle();
      check("clr_raise_addr", err_addr, 32'h2000_0040);

      // Simultaneous read and write to the same RAM word: read first, then write.
      @(posedge clk);
      #1;
      d_addr    = 32'h0000_0020;
      d_wr_data = 32'h7777_8888;
      d_wr_be   = 4'hF;
      d_rd_req  = 1'b1;
      d_wr_req  = 1'b1;
      e.is_rd = 1'b1; e.name = "both_rd"; e.data = mem_m[8]; e.cyc = cyc + 1;
      sb.push_back(e);
      e.is_rd = 1'b0; e.name = "both_wr"; e.data = '0; e.cyc = cyc + 2;
      sb.push_back(e);
      mem_m[8] = 32'h7777_8888;
      wait_ready(1'b1, "both_rd");
      @(posedge clk);
      #1;
      d_rd_req = 1'b0;
      wait_ready(1'b0, "both_wr");
      idle();
      xact("both_rdback", 1'b1, 32'h0000_0020, 32'h0, 4'h0, 0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         tmp = $urandom();
         seen = int'($urandom_range(0, 9));
         rg = (seen < 5) ? 4'h0 : (seen < 8) ? 4'h1 : 4'($urandom_range(2, 15));
         if (rg == 4'h0) addr = {4'h0, tmp[27:14], 8'h0, tmp[3:0], 2'b00};
         else addr = {rg, tmp[27:0]};
         rdata_v = $urandom();
         xact("rnd", 1'($urandom_range(0, 1)), addr, $urandom(), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, TO + 2)), ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();

      // Reset in the middle of a peripheral access; a late ack must be ignored.
      ack_k      = 0;
      exp_p_addr = 32'h1000_0008;
      exp_p_wr   = 1'b0;
      @(posedge clk);
      #1;
      d_addr   = 32'h1000_0008;
      d_rd_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("mid_preq_before", 32'(p_req), 32'h1);
      rstb = 1'b0;
      @(negedge clk);
      check("mid_rst_rd_ready", 32'(d_rd_ready), 32'h0);
      @(posedge clk);
      #1;
      check("mid_rst_preq", 32'(p_req), 32'h0);
      rstb       = 1'b1;
      d_rd_req   = 1'b0;
      man_ack    = 1'b1;
      err_m      = 1'b0;
      err_addr_m = '0;
      @(posedge clk);
      #1;
      man_ack = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (d_rd_ready || d_wr_ready || p_req) seen++;
      end
      check("late_ack_quiet", 32'(seen), 32'h0);
      idle();

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("sb_drain", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
